wb_cmd_master: RTL and testbench

- Wishbone initiator for the monitor's 16-bit register bus. It converts single commands from a local controller (serial debug or sequencer) into Wishbone classic single-word cycles.
- Supports write commands and short incrementing-address read bursts of 1-4 words, so multi-word registers such as the 48-bit time can be read in one command.
- Returns each read word, or a write completion, on a valid/ready response port.
- A bus watchdog terminates cycles to slaves that never acknowledge.

---
 rtl/wb_cmd_master.sv | 179 +++++++++++++++++
 tb/tb_wb_cmd_master.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: turns single local commands into single-word bus
// cycles (writes, 1-4 word incrementing reads) with a per-cycle ack watchdog.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_WIDTH = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [15:0] cmd_adr,
  input  logic [15:0] cmd_dat,
  input  logic [1:0]  cmd_len,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_dat,
  output logic        resp_err,
  output logic        resp_last,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [15:0] wb_adr_o,
  output logic [15:0] wb_dat_o,
  input  logic [15:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [15:0]         adr_q, adr_d;
  logic [15:0]         dat_q, dat_d;
  logic [1:0]          rem_q, rem_d;
  logic [TO_WIDTH-1:0] wd_q, wd_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                cyc_q, cyc_d;
  logic                wb_we_q, wb_we_d;
  logic [15:0]         wb_adr_q, wb_adr_d;
  logic [15:0]         wb_dat_q, wb_dat_d;
  logic                resp_valid_q, resp_valid_d;
  logic [15:0]         resp_dat_q, resp_dat_d;
  logic                resp_err_q, resp_err_d;
  logic                resp_last_q, resp_last_d;
  logic                timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (wd_q == TO_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      rem_q        <= '0;
      wd_q         <= '0;
      cmd_ready_q  <= 1'b1;
      cyc_q        <= 1'b0;
      wb_we_q      <= 1'b0;
      wb_adr_q     <= '0;
      wb_dat_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_dat_q   <= '0;
      resp_err_q   <= 1'b0;
      resp_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      rem_q        <= rem_d;
      wd_q         <= wd_d;
      cmd_ready_q  <= cmd_ready_d;
      cyc_q        <= cyc_d;
      wb_we_q      <= wb_we_d;
      wb_adr_q     <= wb_adr_d;
      wb_dat_q     <= wb_dat_d;
      resp_valid_q <= resp_valid_d;
      resp_dat_q   <= resp_dat_d;
      resp_err_q   <= resp_err_d;
      resp_last_q  <= resp_last_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    rem_d        = rem_q;
    wd_d         = wd_q;
    cmd_ready_d  = cmd_ready_q;
    cyc_d        = cyc_q;
    wb_we_d      = wb_we_q;
    wb_adr_d     = wb_adr_q;
    wb_dat_d     = wb_dat_q;
    resp_valid_d = resp_valid_q;
    resp_dat_d   = resp_dat_q;
    resp_err_d   = resp_err_q;
    resp_last_d  = resp_last_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          we_d        = cmd_we;
          adr_d       = cmd_adr;
          dat_d       = cmd_we ? cmd_dat : '0;
          rem_d       = cmd_we ? 2'd0 : cmd_len;
          wd_d        = '0;
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          wb_we_d     = cmd_we;
          wb_adr_d    = cmd_adr;
          wb_dat_d    = cmd_we ? cmd_dat : '0;
          state_d     = BUS;
        end
      end
      BUS: begin
        wd_d = wd_q + TO_WIDTH'(1);
        // Ack is tested first so an ack on the final watchdog cycle still completes.
        if (wb_ack_i || timeout_hit) begin
          cyc_d        = 1'b0;
          wb_we_d      = 1'b0;
          wb_adr_d     = '0;
          wb_dat_d     = '0;
          resp_valid_d = 1'b1;
          state_d      = RESP;
          if (wb_ack_i) begin
            resp_dat_d  = we_q ? 16'h0000 : wb_dat_i;
            resp_err_d  = 1'b0;
            resp_last_d = (rem_q == 2'd0);
          end else begin
            resp_dat_d  = '0;
            resp_err_d  = 1'b1;
            resp_last_d = 1'b1;
            rem_d       = '0;
          end
        end
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_dat_d   = '0;
          resp_err_d   = 1'b0;
          resp_last_d  = 1'b0;
          if (resp_last_q) begin
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
          end else begin
            adr_d    = adr_q + 16'd1;
            rem_d    = rem_q - 2'd1;
            wd_d     = '0;
            cyc_d    = 1'b1;
            wb_we_d  = we_q;
            wb_adr_d = adr_q + 16'd1;
            wb_dat_d = dat_q;
            state_d  = BUS;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready  = cmd_ready_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_we_o    = wb_we_q;
  assign wb_adr_o   = wb_adr_q;
  assign wb_dat_o   = wb_dat_q;
  assign resp_valid = resp_valid_q;
  assign resp_dat   = resp_dat_q;
  assign resp_err   = resp_err_q;
  assign resp_last  = resp_last_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: table of commands with expected bus cycles and
// responses fed to scoreboard queues, plus hand-written corner sequences.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [15:0] cmd_adr, cmd_dat;
  logic [1:0]  cmd_len;
  logic        resp_valid, resp_ready, resp_err, resp_last;
  logic [15:0] resp_dat;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic        wb_ack_i, slave_ack, stray_ack;

  int checks = 0;
  int errors = 0;

  wb_cmd_master #(.TIMEOUT(16), .TO_WIDTH(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_len(cmd_len),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_dat(resp_dat),
    .resp_err(resp_err), .resp_last(resp_last),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;
  assign wb_ack_i = slave_ack | stray_ack;

  typedef struct {
    logic        we;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [1:0]  len;
    int          delay;
    logic        noack;
    int          nwords;
    logic [15:0] rd0, rd1, rd2, rd3;
    logic        err;
  } vec_t;

  typedef struct { logic [15:0] adr; logic we; logic [15:0] dat; int len; } bus_exp_t;
  typedef struct { logic [15:0] dat; logic err; logic last; } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  vec_t     vecs[7];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave model: fixed register contents, acks after ack_delay extra cycles.
  function automatic logic [15:0] slave_rd(logic [15:0] a);
    case (a)
      16'h0006: return 16'h1111;
      16'h0007: return 16'h2222;
      16'h0008: return 16'h3333;
      16'hFFFF: return 16'hBEEF;
      16'h0000: return 16'hCAFE;
      default:  return {a[7:0] ^ 8'h3C, a[15:8]};
    endcase
  endfunction

  int   ack_delay = 0;
  logic noack = 1'b0;
  int   scnt = 0;

  initial begin slave_ack = 1'b0; stray_ack = 1'b0; wb_dat_i = '0; end

  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o && !noack && scnt == ack_delay) begin
      slave_ack = 1'b1;
      wb_dat_i  = slave_rd(wb_adr_o);
    end else begin
      slave_ack = 1'b0;
    end
    scnt = wb_cyc_o ? scnt + 1 : 0;
  end

  // Bus monitor: each cycle start is matched against the next expected cycle.
  logic     cyc_prev = 1'b0;
  int       hi_cnt = 0;
  bus_exp_t cur;
  always @(negedge clk) begin
    if (!wb_rst_i) begin
      check("cyc_eq_stb", wb_stb_o, wb_cyc_o);
      if (wb_cyc_o && !cyc_prev) begin
        hi_cnt = 1;
        if (bus_q.size() == 0) begin
          check("unexpected_bus_cycle", 1, 0);
          cur = '{adr: 16'h0, we: 1'b0, dat: 16'h0, len: 0};
        end else begin
          cur = bus_q.pop_front();
          check("bus_adr", wb_adr_o, cur.adr);
          check("bus_we", wb_we_o, cur.we);
          check("bus_dat", wb_dat_o, cur.dat);
        end
      end else if (wb_cyc_o) begin
        hi_cnt++;
      end else if (cyc_prev && cur.len != 0) begin
        check("bus_cycle_len", hi_cnt, cur.len);
      end
    end
    cyc_prev = wb_cyc_o;
  end

  // Response monitor: handshakes pop the scoreboard; stalled words must hold.
  logic        hold_prev = 1'b0;
  logic [15:0] hold_dat;
  logic        hold_err, hold_last;
  rsp_exp_t    r;
  always @(negedge clk) begin
    if (wb_rst_i) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("resp_hold_valid", resp_valid, 1);
        check("resp_hold_dat", resp_dat, hold_dat);
        check("resp_hold_err", resp_err, hold_err);
        check("resp_hold_last", resp_last, hold_last);
      end
      if (resp_valid && resp_ready) begin
        if (rsp_q.size() == 0) begin
          check("unexpected_response", 1, 0);
        end else begin
          r = rsp_q.pop_front();
          check("resp_dat", resp_dat, r.dat);
          check("resp_err", resp_err, r.err);
          check("resp_last", resp_last, r.last);
        end
      end
      hold_prev = resp_valid && !resp_ready;
      hold_dat  = resp_dat;
      hold_err  = resp_err;
      hold_last = resp_last;
    end
  end

  task automatic push_exp(vec_t v);
    logic [15:0] rd[4];
    rd = '{v.rd0, v.rd1, v.rd2, v.rd3};
    for (int i = 0; i < v.nwords; i++) begin
      bus_q.push_back('{adr: v.adr + 16'(i), we: v.we, dat: (v.we ? v.dat : 16'h0),
                        len: (v.noack ? 16 : v.delay + 1)});
      rsp_q.push_back('{dat: rd[i], err: v.err, last: (i == v.nwords - 1)});
    end
  endtask

  task automatic send(vec_t v);
    int n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
    ack_delay = v.delay;
    noack     = v.noack;
    cmd_we    = v.we;
    cmd_adr   = v.adr;
    cmd_dat   = v.dat;
    cmd_len   = v.len;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(rsp_q.size() == 0 && bus_q.size() == 0 && cmd_ready) && n < 400) begin
      @(posedge clk); #1; n++;
    end
    check("wait_idle_bound", (n < 400), 1);
  endtask

  task automatic wait_resp_valid();
    int n = 0;
    while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("resp_valid_seen", resp_valid, 1);
  endtask

  vec_t v;

  initial begin
    //          we  adr       dat       len  dly  noack nw  rd0       rd1       rd2       rd3    err
    vecs[0] = '{1'b1, 16'h0005, 16'h00A5, 2'd0, 0, 1'b0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0, 1'b0};
    vecs[1] = '{1'b0, 16'h0006, 16'h0000, 2'd2, 0, 1'b0, 3, 16'h1111, 16'h2222, 16'h3333, 16'h0, 1'b0};
    vecs[2] = '{1'b0, 16'h0020, 16'h0000, 2'd0, 3, 1'b0, 1, 16'h1C00, 16'h0000, 16'h0000, 16'h0, 1'b0};
    vecs[3] = '{1'b0, 16'h0030, 16'h0000, 2'd3, 0, 1'b1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0, 1'b1};
    vecs[4] = '{1'b0, 16'h0030, 16'h0000, 2'd1, 15, 1'b0, 2, 16'h0C00, 16'h0D00, 16'h0000, 16'h0, 1'b0};
    vecs[5] = '{1'b1, 16'h1234, 16'hBEEF, 2'd3, 2, 1'b0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0, 1'b0};
    vecs[6] = '{1'b0, 16'h0040, 16'h0000, 2'd3, 1, 1'b0, 4, 16'h7C00, 16'h7D00, 16'h7E00, 16'h7F00, 1'b0};

    wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
    cmd_len = '0; resp_ready = 1'b1;
    #12;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_outputs_misc", {wb_we_o, wb_adr_o, wb_dat_o, resp_dat, resp_err, resp_last}, 0);
    @(posedge clk); #1 wb_rst_i = 1'b0;

    for (int i = 0; i < 7; i++) begin
      push_exp(vecs[i]);
      send(vecs[i]);
      wait_idle();
    end

    // Backpressure with address wrap
    v = '{1'b0, 16'hFFFF, 16'h0000, 2'd1, 1, 1'b0, 2, 16'hBEEF, 16'hCAFE, 16'h0, 16'h0, 1'b0};
    resp_ready = 1'b0;
    push_exp(v);
    send(v);
    wait_resp_valid();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_no_bus", wb_cyc_o, 0);
      check("bp_cmd_ready", cmd_ready, 0);
    end
    resp_ready = 1'b1;
    wait_idle();

    // Reset during BUS of a 4-word read
    v = '{1'b0, 16'h0050, 16'h0000, 2'd3, 0, 1'b1, 1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b1};
    push_exp(v);
    send(v);
    repeat (3) @(posedge clk);
    #2 wb_rst_i = 1'b1;
    #1;
    check("midrst_cyc", wb_cyc_o, 0);
    check("midrst_stb", wb_stb_o, 0);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    bus_q.delete();
    rsp_q.delete();
    @(posedge clk); @(posedge clk); #1 wb_rst_i = 1'b0;
    check("post_rst_cmd_ready", cmd_ready, 1);
    push_exp(vecs[1]);
    send(vecs[1]);
    wait_idle();

    // Stray acks in IDLE and RESP
    @(posedge clk); #1 stray_ack = 1'b1;
    @(posedge clk); #1 stray_ack = 1'b0;
    check("stray_idle_cmd_ready", cmd_ready, 1);
    check("stray_idle_cyc", wb_cyc_o, 0);
    check("stray_idle_resp", resp_valid, 0);
    v = '{1'b0, 16'h0007, 16'h0000, 2'd1, 0, 1'b0, 2, 16'h2222, 16'h3333, 16'h0, 16'h0, 1'b0};
    resp_ready = 1'b0;
    push_exp(v);
    send(v);
    wait_resp_valid();
    stray_ack = 1'b1;
    @(posedge clk); #1 stray_ack = 1'b0;
    check("stray_resp_cyc", wb_cyc_o, 0);
    check("stray_resp_valid", resp_valid, 1);
    @(posedge clk); #1 resp_ready = 1'b1;
    wait_idle();

    repeat (5) @(posedge clk);
    #1;
    check("final_bus_q_empty", bus_q.size(), 0);
    check("final_rsp_q_empty", rsp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
